frequency_meter: RTL and testbench

- Measures the frequency of an external square wave by counting its rising edges over a fixed gate window of `clk` cycles.
- It is the measuring end of the divider chain: it verifies divider taps on the board and reports input frequencies to the display logic.
- Results are latched and held until the next measurement completes.
- The block is fully synchronous to `clk`; `sig_in` is treated as asynchronous.

---
 rtl/freq_meter_pkg.sv | 24 ++
 rtl/edge_sync.sv | 41 ++++
 rtl/frequency_meter.sv | 141 ++++++++++++++
 tb/tb_frequency_meter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// ============================================================================
//  Module   : freq_meter_pkg
//  Brief    : Shared FSM state type and default sizing for frequency_meter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_meter_pkg;

  // Default sizing: 1 s gate at 50 MHz, 18-bit edge count
  localparam int unsigned c_gate_cycles_dflt = 50_000_000;
  localparam int unsigned c_gate_w_dflt      = 26;
  localparam int unsigned c_cnt_w_dflt       = 18;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } fm_state_t;

endpackage : freq_meter_pkg

`default_nettype wire

// File: rtl/edge_sync.sv
// ============================================================================
//  Module   : edge_sync
//  Brief    : 2-FF synchronizer for an asynchronous input followed by a
//             registered rising-edge detector (one-cycle pulse on edge_p).
//             Latency is 3 clk edges from an input rise to edge_p.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic sig_in,
  output logic edge_p
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_edge;

  // Synchronize sig_in, remember the previous synchronized level, register the rise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= r_sync2 & ~r_prev;
    end
  end

  assign edge_p = r_edge;

endmodule : edge_sync

`default_nettype wire

// File: rtl/frequency_meter.sv
// ============================================================================
//  Module   : frequency_meter
//  Brief    : Counts rising edges of an asynchronous square wave over a gate
//             window of GATE_CYCLES clk cycles and holds the latched result.
//             Optional build macro FREQ_METER_CONTINUOUS_EN: back-to-back
//             measurements starting automatically after reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frequency_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = c_gate_cycles_dflt,
  parameter int unsigned GATE_W      = c_gate_w_dflt,
  parameter int unsigned CNT_W       = c_cnt_w_dflt
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [GATE_W-1:0] c_gate_last = GATE_W'(GATE_CYCLES - 1);

  fm_state_t         r_state;
  fm_state_t         w_state_next;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic [CNT_W-1:0]  w_edge_cnt_inc;
  logic              r_ovf;
  logic              w_ovf_inc;
  logic              w_edge_p;
  logic              w_last_gate;
  logic              w_at_max;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

`ifdef FREQ_METER_CONTINUOUS_EN
  // start has no function when measurements free-run
  logic w_unused_start;
  assign w_unused_start = start;
`endif

  edge_sync u_edge_sync (
    .clk    (clk),
    .rstn   (rstn),
    .sig_in (sig_in),
    .edge_p (w_edge_p)
  );

  assign w_last_gate    = (r_gate_cnt == c_gate_last);
  assign w_at_max       = &r_edge_cnt;
  // Saturating increment; an edge arriving at all-ones marks overflow instead
  assign w_edge_cnt_inc = (w_edge_p && !w_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_ovf_inc      = r_ovf | (w_edge_p & w_at_max);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status decode
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    valid        = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef FREQ_METER_CONTINUOUS_EN
        w_state_next = GATE;
`else
        if (start) begin
          w_state_next = GATE;
        end
`endif
      end
      GATE: begin
        busy = 1'b1;
        if (w_last_gate) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy  = 1'b1;
        valid = 1'b1;
`ifdef FREQ_METER_CONTINUOUS_EN
        w_state_next = GATE;
`else
        w_state_next = IDLE;
`endif
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Gate and edge counters run only in GATE; every other state clears them
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (r_state == GATE) begin
      r_gate_cnt <= r_gate_cnt + GATE_W'(1);
      r_edge_cnt <= w_edge_cnt_inc;
      r_ovf      <= w_ovf_inc;
    end else begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
    end
  end

  // Result capture on the edge entering DONE so the new value is visible
  // together with valid; it includes an edge seen on the last GATE cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if ((r_state == GATE) && w_last_gate) begin
      r_count    <= w_edge_cnt_inc;
      r_overflow <= w_ovf_inc;
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;

endmodule : frequency_meter

`default_nettype wire

// File: tb/tb_frequency_meter.sv
// ============================================================================
//  Module   : tb_frequency_meter
//  Brief    : Directed self-checking bench for frequency_meter
//             (GATE_CYCLES=100, GATE_W=7, CNT_W=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frequency_meter;

  localparam int GC = 100;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sig_in = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       valid;
  logic [3:0] count;
  logic       overflow;

  int   n_checks = 0;
  int   n_fail = 0;
  int   sig_period = 0;
  logic sig_manual = 1'b0;
  int   nv;
  int   nb;
  int   n;

  frequency_meter #(
    .GATE_CYCLES (GC),
    .GATE_W      (7),
    .CNT_W       (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sig_in   (sig_in),
    .start    (start),
    .busy     (busy),
    .valid    (valid),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Square-wave source: periodic when sig_period >= 2, else follows sig_manual
  initial begin : g_sig_gen
    int ph = 0;
    forever begin
      @(negedge clk);
      if (sig_period < 2) begin
        sig_in = sig_manual;
      end else begin
        ph = (ph + 1) % sig_period;
        sig_in = (ph < sig_period / 2);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One single-shot measurement: start pulse, GC gate cycles, DONE, back to IDLE
  task automatic measure(input int rise_at, input int restart_at,
                         input logic [3:0] exp_cnt, input logic exp_ovf, input string tag);
    int bad;
    bad = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    for (int k = 1; k <= GC; k++) begin
      start = (k == restart_at);
      step();
      if (k == rise_at) sig_manual = 1'b1;
      if (k < GC && (valid !== 1'b0 || busy !== 1'b1)) bad++;
    end
    start = 1'b0;
    check({tag, "_gate_window"}, bad, 0);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_busy_done"}, busy, 1);
    check({tag, "_count"}, count, exp_cnt);
    check({tag, "_overflow"}, overflow, exp_ovf);
    step();
    check({tag, "_valid_drop"}, valid, 0);
    check({tag, "_busy_drop"}, busy, 0);
    check({tag, "_count_hold"}, count, exp_cnt);
  endtask

  initial begin
    // Reset with a random input
    rstn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sig_manual = 1'($urandom_range(0, 1));
      step();
    end
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    sig_manual = 1'b0;
    repeat (3) step();

`ifndef FREQ_METER_CONTINUOUS_EN
    rstn = 1'b1;
    step();
    check("rel_busy", busy, 0);
    check("rel_count", count, 0);
    nv = 0;
    nb = 0;
    repeat (200) begin
      step();
      if (valid !== 1'b0) nv++;
      if (busy !== 1'b0) nb++;
    end
    check("idle_no_valid", nv, 0);
    check("idle_no_busy", nb, 0);

    sig_period = 10;
    repeat (20) step();
    measure(-1, -1, 4'd10, 1'b0, "nominal");

    sig_period = 4;
    repeat (20) step();
    measure(-1, -1, 4'd15, 1'b1, "saturate");

    sig_period = 20;
    repeat (40) step();
    measure(-1, -1, 4'd5, 1'b0, "period20");

    sig_period = 10;
    repeat (20) step();
    measure(-1, 40, 4'd10, 1'b0, "restart");
    nv = 0;
    repeat (150) begin
      step();
      if (valid !== 1'b0) nv++;
    end
    check("restart_single_valid", nv, 0);

    // Abort mid-GATE with reset
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    rstn = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_count", count, 0);
    check("abort_overflow", overflow, 0);
    step();
    rstn = 1'b1;
    nv = 0;
    nb = 0;
    repeat (150) begin
      step();
      if (valid !== 1'b0) nv++;
      if (busy !== 1'b0) nb++;
    end
    check("abort_no_valid", nv, 0);
    check("abort_no_busy", nb, 0);

    // Window boundary: edge_p on the last GATE cycle counts, one later does not
    sig_period = 0;
    sig_manual = 1'b0;
    repeat (10) step();
    measure(96, -1, 4'd1, 1'b0, "edge_last");
    sig_manual = 1'b0;
    repeat (10) step();
    measure(97, -1, 4'd0, 1'b0, "edge_late");
`else
    rstn = 1'b1;
    sig_period = 10;
    check("cont_rel_busy", busy, 0);
    for (int w = 0; w < 4; w++) begin
      n = 0;
      nb = 0;
      do begin
        step();
        n++;
        if (busy !== 1'b1) nb++;
      end while (valid !== 1'b1 && n < 300);
      check("cont_interval", n, 101);
      check("cont_busy", nb, 0);
      if (w > 0) begin
        check("cont_count", count, 10);
        check("cont_overflow", overflow, 0);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_frequency_meter

`default_nettype wire
